mac_dot_seq: RTL



---
 rtl/mac_dot_seq.sv | 98 +++++++++
 1 files changed

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer around an external combinational MAC (Y = A*B + C).
// Optional sticky wrap flag output `ovf` is enabled by defining MAC_DOT_OVF_EN.
module mac_dot_seq #(
  parameter int WIDTH_A = 5,
  parameter int WIDTH_B = 7,
  parameter int LEN_W   = 8,
  localparam int ACC_W  = WIDTH_A + WIDTH_B
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_A-1:0] in_a,
  input  logic [WIDTH_B-1:0] in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_data,
  output logic               busy,
`ifdef MAC_DOT_OVF_EN
  output logic               ovf,
`endif
  output logic [WIDTH_A-1:0] mac_a,
  output logic [WIDTH_B-1:0] mac_b,
  output logic [ACC_W-1:0]   mac_c,
  input  logic [ACC_W-1:0]   mac_y
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [ACC_W-1:0]   acc_d;
  logic [LEN_W-1:0]   cnt_d;
  logic               beat;

  assign beat  = (state_q == RUN) && in_valid;
  assign acc_d = mac_y;
  assign cnt_d = cnt_q - LEN_W'(1);

`ifdef MAC_DOT_OVF_EN
  logic ovf_q;
  // product fits in ACC_W bits, so a smaller sum means exactly one wrap
  logic wrap;
  assign wrap = mac_y < acc_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
`ifdef MAC_DOT_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (start) begin
          acc_q <= '0;
`ifdef MAC_DOT_OVF_EN
          ovf_q <= 1'b0;
`endif
          if (len == '0) begin
            state_q <= DONE;
          end else begin
            cnt_q   <= len;
            state_q <= RUN;
          end
        end
        RUN: if (beat) begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
`ifdef MAC_DOT_OVF_EN
          if (wrap) ovf_q <= 1'b1;
`endif
          if (cnt_q == LEN_W'(1)) state_q <= DONE;
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // all outputs decode straight from registers, so rst clears them at once
  assign in_ready  = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_valid ? acc_q : '0;
  assign mac_a     = in_ready ? in_a  : '0;
  assign mac_b     = in_ready ? in_b  : '0;
  assign mac_c     = in_ready ? acc_q : '0;
`ifdef MAC_DOT_OVF_EN
  assign ovf       = out_valid & ovf_q;
`endif

endmodule
